// File: rtl/dram_req_arbiter.sv
// dram_req_arbiter
//   Round-robin arbiter/sequencer that shares one DRAM burst port among
//   NUM_REQ requesters. It serves one burst at a time:
//   IDLE -> ISSUE -> BURST -> RECOVER -> IDLE.
//   A watchdog aborts a burst that runs MAX_WAIT cycles without dram_complete.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/we/addr/wdata   per-requester request (packed buses)
//   req_accept            one-hot pulse when a request is latched
//   req_wbeat             one-hot, current write beat consumed this cycle
//   req_rvalid/req_rdata  registered read beat for the granted requester
//   req_done / req_err    one-hot pulse, burst completed / aborted
//   addr, read_en, write_en, wdata    to DRAM
//   dram_ready, dram_complete, valid, rdata    from DRAM
module dram_req_arbiter #(
  parameter int NUM_REQ            = 4,
  parameter int ADDRESS_LEN        = 16,
  parameter int BURST_ACCESS_WIDTH = 32,
  parameter int RECOVERY_CYCLES    = 8,
  parameter int MAX_WAIT           = 256
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ-1:0]                    req_we,
  input  logic [NUM_REQ*ADDRESS_LEN-1:0]        req_addr,
  input  logic [NUM_REQ*BURST_ACCESS_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]                    req_accept,
  output logic [NUM_REQ-1:0]                    req_wbeat,
  output logic [NUM_REQ-1:0]                    req_rvalid,
  output logic [BURST_ACCESS_WIDTH-1:0]         req_rdata,
  output logic [NUM_REQ-1:0]                    req_done,
  output logic [NUM_REQ-1:0]                    req_err,
  output logic [ADDRESS_LEN-1:0]                addr,
  output logic                                  read_en,
  output logic                                  write_en,
  output logic [BURST_ACCESS_WIDTH-1:0]         wdata,
  input  logic                                  dram_ready,
  input  logic                                  dram_complete,
  input  logic                                  valid,
  input  logic [BURST_ACCESS_WIDTH-1:0]         rdata
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int RW = $clog2(RECOVERY_CYCLES + 1);
  localparam int BW = BURST_ACCESS_WIDTH;
  localparam int AL = ADDRESS_LEN;

  typedef enum logic [1:0] {IDLE, ISSUE, BURST, RECOVER} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                  we_q, we_d;
  logic [AL-1:0]         addr_q, addr_d;
  logic                  rd_en_q, rd_en_d;
  logic                  wr_en_q, wr_en_d;
  logic [WW-1:0]         wd_q, wd_d;
  logic [RW-1:0]         rc_q, rc_d;
  logic [NUM_REQ-1:0]    accept_q, accept_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic [NUM_REQ-1:0]    err_q, err_d;
  logic [NUM_REQ-1:0]    rvalid_q, rvalid_d;
  logic [BW-1:0]         rdata_q, rdata_d;

  logic                  pick_vld;
  logic [IW-1:0]         pick_idx;
  logic                  grant;

  // Round-robin pick: walk offsets from the far end down to 0 so the
  // requester closest to rr_ptr (offset 0 first) is the last, winning write.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        pick_vld = 1'b1;
        pick_idx = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    we_d     = we_q;
    addr_d   = addr_q;
    rd_en_d  = rd_en_q;
    wr_en_d  = wr_en_q;
    wd_d     = wd_q;
    rc_d     = rc_q;
    accept_d = '0;
    done_d   = '0;
    err_d    = '0;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          idx_d              = pick_idx;
          we_d               = req_we[pick_idx];
          addr_d             = req_addr[int'(pick_idx)*AL +: AL];
          accept_d[pick_idx] = 1'b1;
          rr_ptr_d           = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);
          state_d            = ISSUE;
        end
      end
      ISSUE: begin
        if (dram_ready) begin
          rd_en_d = ~we_q;
          wr_en_d = we_q;
          wd_d    = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (!we_q && valid) begin
          rvalid_d[idx_q] = 1'b1;
          rdata_d         = rdata;
        end
        // Completion is checked first so it wins over a coincident timeout.
        if (dram_complete) begin
          rd_en_d       = 1'b0;
          wr_en_d       = 1'b0;
          done_d[idx_q] = 1'b1;
          rc_d          = '0;
          state_d       = RECOVER;
        end else if (wd_q >= WW'(MAX_WAIT - 1)) begin
          rd_en_d      = 1'b0;
          wr_en_d      = 1'b0;
          err_d[idx_q] = 1'b1;
          rc_d         = '0;
          state_d      = RECOVER;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      RECOVER: begin
        if (rc_q >= RW'(RECOVERY_CYCLES - 1)) state_d = IDLE;
        else                                 rc_d    = rc_q + RW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      wd_q     <= '0;
      rc_q     <= '0;
      accept_q <= '0;
      done_q   <= '0;
      err_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      rd_en_q  <= rd_en_d;
      wr_en_q  <= wr_en_d;
      wd_q     <= wd_d;
      rc_q     <= rc_d;
      accept_q <= accept_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // A grant is held from accept until the burst ends.
  assign grant = (state_q == ISSUE) || (state_q == BURST);

  // Write beats pass straight through so the DRAM sees the requester's
  // current beat in the same cycle it pulses valid.
  always_comb begin
    req_wbeat = '0;
    wdata     = '0;
    if (state_q == BURST && we_q) begin
      wdata            = req_wdata[int'(idx_q)*BW +: BW];
      req_wbeat[idx_q] = valid;
    end
  end

  assign addr       = grant ? addr_q : '0;
  assign read_en    = rd_en_q;
  assign write_en   = wr_en_q;
  assign req_accept = accept_q;
  assign req_done   = done_q;
  assign req_err    = err_q;
  assign req_rvalid = rvalid_q;
  assign req_rdata  = rdata_q;

endmodule

// File: tb/tb_dram_req_arbiter.sv
module tb_dram_req_arbiter;
  localparam int N  = 4;
  localparam int AL = 16;
  localparam int BW = 32;
  localparam int RC = 8;
  localparam int MW = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]    req_valid, req_we;
  logic [N*AL-1:0] req_addr;
  logic [N*BW-1:0] req_wdata;
  logic [N-1:0]    req_accept, req_wbeat, req_rvalid, req_done, req_err;
  logic [BW-1:0]   req_rdata, wdata, rdata;
  logic [AL-1:0]   addr;
  logic            read_en, write_en, dram_ready, dram_complete, valid;

  dram_req_arbiter #(.NUM_REQ(N), .ADDRESS_LEN(AL), .BURST_ACCESS_WIDTH(BW),
                     .RECOVERY_CYCLES(RC), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_accept(req_accept),
    .req_wbeat(req_wbeat), .req_rvalid(req_rvalid), .req_rdata(req_rdata),
    .req_done(req_done), .req_err(req_err), .addr(addr), .read_en(read_en),
    .write_en(write_en), .wdata(wdata), .dram_ready(dram_ready),
    .dram_complete(dram_complete), .valid(valid), .rdata(rdata));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] pattern(int r, int b);
    return 32'hD000_0000 | 32'(r << 8) | 32'(b);
  endfunction

  // ---------------- DRAM model + monitor (negedge) ----------------
  int cmpl_at = 10;   // burst cycle at which complete is raised, 0 = never
  int cnt = 0, row = 0, en_len = 0, last_len = 0, gap = 0, last_gap = 0, min_gap = 1000;
  int rv_cnt = 0, done_cnt = 0, err_cnt = 0, both_en = 0, wbeats = 0;
  bit prev_en = 1'b0, seen_burst = 1'b0;
  logic [N-1:0]  wbeat_mask = '0;
  logic [BW-1:0] rd_log [8];
  int            wb_idx [N];
  bit            written [16][8];
  logic [BW-1:0] mem [16][8];

  always @(negedge clk) begin
    if (req_rvalid != '0) begin
      if (rv_cnt < 8) rd_log[rv_cnt] = req_rdata;
      rv_cnt++;
    end
    if (req_done != '0) done_cnt++;
    if (req_err != '0) err_cnt++;
    if (read_en && write_en) both_en++;
    if (!rst_n) seen_burst = 1'b0;
    if (read_en || write_en) begin
      if (!prev_en) begin
        if (seen_burst) begin
          last_gap = gap;
          if (gap < min_gap) min_gap = gap;
        end
        en_len = 0; cnt = 0; row = int'(addr[3:0]);
        rv_cnt = 0; wbeats = 0; wbeat_mask = '0;
      end
      en_len++; cnt++;
    end else begin
      if (prev_en) begin last_len = en_len; seen_burst = rst_n; gap = 0; end
      gap++;
      cnt = 0;
    end
    prev_en = read_en || write_en;
    valid = (read_en || write_en) && cnt >= 2 && cnt <= 9;
    dram_complete = (read_en || write_en) && cnt == cmpl_at;
    if (valid) rdata = written[row][cnt-2] ? mem[row][cnt-2] : pattern(row, cnt-2);
    else       rdata = '0;
    #1;
    if (valid && write_en) begin
      mem[row][cnt-2] = wdata;
      written[row][cnt-2] = 1'b1;
      wbeats++;
      wbeat_mask |= req_wbeat;
    end
    for (int i = 0; i < N; i++) begin
      if (req_accept[i])     wb_idx[i] = 0;
      else if (req_wbeat[i]) wb_idx[i]++;
      req_wdata[i*BW +: BW] = 32'hA0 + 32'(wb_idx[i]);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_accept(output logic [N-1:0] a);
    a = '0;
    for (int i = 0; i < 200 && a == '0; i++) begin
      @(negedge clk);
      a = req_accept;
    end
  endtask

  task automatic wait_end(output logic [N-1:0] d, output logic [N-1:0] e, output logic en);
    d = '0; e = '0; en = 1'b1;
    for (int i = 0; i < 200 && (d | e) == '0; i++) begin
      @(negedge clk);
      d = req_done; e = req_err; en = read_en | write_en;
    end
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [N-1:0] mask;
    logic [N-1:0] we;
    logic [N-1:0] exp;
  } vec_t;
  vec_t vecs [10];

  logic [N-1:0] a, d, e;
  logic en;
  int dsnap, esnap;
  logic [N-1:0] order [5];

  initial begin
    // round-robin table from rr_ptr = 0 after reset
    vecs[0] = '{4'b0001, 4'b0000, 4'b0001};
    vecs[1] = '{4'b0001, 4'b0001, 4'b0001};
    vecs[2] = '{4'b1001, 4'b1000, 4'b1000};
    vecs[3] = '{4'b1001, 4'b0000, 4'b0001};
    vecs[4] = '{4'b0110, 4'b0010, 4'b0010};
    vecs[5] = '{4'b0011, 4'b0000, 4'b0001};
    vecs[6] = '{4'b1111, 4'b0000, 4'b0010};
    vecs[7] = '{4'b0101, 4'b0100, 4'b0100};
    vecs[8] = '{4'b0011, 4'b0000, 4'b0001};
    vecs[9] = '{4'b1100, 4'b1100, 4'b0100};
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    req_valid = '0; req_we = '0; req_addr = '0; dram_ready = 1'b1;
    do_reset();
    chk("rst_en", {62'd0, read_en, write_en}, 64'd0);
    chk("rst_addr_wdata", {addr, wdata}, 64'd0);
    chk("rst_pulses", 64'({req_accept, req_done, req_err, req_rvalid, req_wbeat}), 64'd0);
    chk("rst_rdata", 64'(req_rdata), 64'd0);

    // single read, req 0, addr 5
    req_addr[0*AL +: AL] = 16'd5;
    req_valid = 4'b0001;
    @(negedge clk);
    chk("rd_accept_lat", 64'(req_accept), 64'b0001);
    req_valid = '0;
    @(negedge clk);
    chk("rd_en_issue", {62'd0, read_en, write_en}, 64'b10);
    chk("rd_addr", 64'(addr), 64'd5);
    wait_end(d, e, en);
    chk("rd_done", 64'({d, e}), 64'h10);
    chk("rd_en_drop", 64'(en), 64'd0);
    chk("rd_beats", 64'(rv_cnt), 64'd8);
    for (int b = 0; b < 8; b++) chk($sformatf("rd_data%0d", b), 64'(rd_log[b]), 64'(pattern(5, b)));
    chk("rd_len", 64'(last_len), 64'd10);

    // single write, req 2, addr 3, with dram_ready held low at first
    req_addr[2*AL +: AL] = 16'd3;
    req_we = 4'b0100; dram_ready = 1'b0; req_valid = 4'b0100;
    wait_accept(a);
    chk("wr_accept", 64'(a), 64'b0100);
    req_valid = '0;
    repeat (3) @(negedge clk);
    chk("wr_wait_ready", {62'd0, read_en, write_en}, 64'd0);
    dram_ready = 1'b1;
    @(negedge clk);
    chk("wr_en_issue", {62'd0, read_en, write_en}, 64'b01);
    wait_end(d, e, en);
    chk("wr_done", 64'({d, e}), 64'h40);
    chk("wr_beats", 64'(wbeats), 64'd8);
    chk("wr_beat_mask", 64'(wbeat_mask), 64'b0100);
    // read back addr 3 through requester 1
    req_we = '0; req_addr[1*AL +: AL] = 16'd3; req_valid = 4'b0010;
    wait_accept(a);
    chk("rb_accept", 64'(a), 64'b0010);
    req_valid = '0;
    wait_end(d, e, en);
    chk("rb_done", 64'(d), 64'b0010);
    for (int b = 0; b < 8; b++) chk($sformatf("rb_data%0d", b), 64'(rd_log[b]), 64'(32'hA0 + b));

    // all four requesting continuously from reset
    do_reset();
    req_we = '0; req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_accept(a);
      chk($sformatf("rr_order%0d", i), 64'(a), 64'(order[i]));
    end
    req_valid = '0;
    wait_end(d, e, en);
    chk("rr_gap", 64'(last_gap), 64'(RC + 2));

    // table-driven arbitration
    do_reset();
    for (int i = 0; i < N; i++) req_addr[i*AL +: AL] = 16'(8 + i);
    foreach (vecs[v]) begin
      req_we = vecs[v].we; req_valid = vecs[v].mask;
      wait_accept(a);
      chk($sformatf("tbl_accept%0d", v), 64'(a), 64'(vecs[v].exp));
      req_valid = '0;
      wait_end(d, e, en);
      chk($sformatf("tbl_done%0d", v), 64'({d, e}), 64'({vecs[v].exp, 4'b0000}));
    end

    // watchdog: DRAM never completes
    cmpl_at = 0; req_we = '0; req_valid = 4'b0010;
    wait_accept(a);
    chk("wd_accept", 64'(a), 64'b0010);
    req_valid = '0;
    wait_end(d, e, en);
    chk("wd_err", 64'({d, e}), 64'h02);
    chk("wd_en_drop", 64'(en), 64'd0);
    chk("wd_len", 64'(last_len), 64'(MW));

    // complete on the same cycle the watchdog expires
    cmpl_at = 16; req_valid = 4'b0001;
    wait_accept(a);
    chk("co_accept", 64'(a), 64'b0001);
    req_valid = '0;
    wait_end(d, e, en);
    chk("co_done", 64'({d, e}), 64'h10);
    chk("co_len", 64'(last_len), 64'(MW));
    cmpl_at = 10;

    // reset in the middle of a write burst
    req_we = 4'b0100; req_addr[2*AL +: AL] = 16'd7; req_valid = 4'b0100;
    wait_accept(a);
    chk("mr_accept", 64'(a), 64'b0100);
    req_valid = '0;
    repeat (4) @(negedge clk);
    chk("mr_in_burst", 64'(write_en), 64'd1);
    dsnap = done_cnt; esnap = err_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_en", {62'd0, read_en, write_en}, 64'd0);
    chk("mr_outs", 64'({req_accept, req_done, req_err, req_rvalid, req_wbeat}), 64'd0);
    chk("mr_addr_wdata", {addr, wdata}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("mr_no_pulse", 64'({done_cnt - dsnap, err_cnt - esnap}), 64'd0);
    req_we = '0; req_valid = 4'b1111;
    wait_accept(a);
    chk("mr_first_grant", 64'(a), 64'b0001);
    req_valid = '0;
    wait_end(d, e, en);
    chk("mr_done", 64'(d), 64'b0001);

    chk("never_both_en", 64'(both_en), 64'd0);
    chk("min_gap_ok", 64'(min_gap >= RC + 2), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dram_req_arbiter.md
# dram_req_arbiter

Round-robin arbiter and sequencer sharing the single behavioural DRAM burst port among `NUM_REQ` PIM requesters. It accepts one burst request at a time and drives `read_en`/`write_en`/`addr` to the DRAM until `dram_complete`. It steers per-beat write and read data between the DRAM and the granted requester, then enforces a recovery gap before the next grant. A watchdog aborts any burst that exceeds `MAX_WAIT` cycles.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `ADDRESS_LEN`, from `types`, DRAM address width
- `BURST_ACCESS_WIDTH`, from `types`, beat data width
- `RECOVERY_CYCLES`, 8, idle cycles with `read_en`/`write_en` low after a burst; must be at least TWR_CYCLES+TRP_CYCLES+2
- `MAX_WAIT`, 256, watchdog limit in cycles from issue to `dram_complete`
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  reset; synchronous, active-low (one clock; reset is synchronous and active-low)
- `req_valid`  in  NUM_REQ  per-requester request pending; held until `req_accept`
- `req_we`  in  NUM_REQ  1 = write burst, 0 = read burst
- `req_addr`  in  NUM_REQ*ADDRESS_LEN  packed, requester i at `[i*ADDRESS_LEN +: ADDRESS_LEN]`
- `req_wdata`  in  NUM_REQ*BURST_ACCESS_WIDTH  packed write beat per requester
- `req_accept`  out  NUM_REQ  one-hot, 1-cycle pulse when request is latched
- `req_wbeat`  out  NUM_REQ  one-hot; current `req_wdata` beat consumed this cycle
- `req_rvalid`  out  NUM_REQ  one-hot; `req_rdata` valid for that requester
- `req_rdata`  out  BURST_ACCESS_WIDTH  shared read beat
- `req_done`  out  NUM_REQ  one-hot 1-cycle pulse, burst finished normally
- `req_err`  out  NUM_REQ  one-hot 1-cycle pulse, burst aborted by watchdog
- `addr`  out  ADDRESS_LEN  to DRAM
- `read_en`, `write_en`  out  1  to DRAM; never both high
- `wdata`  out  BURST_ACCESS_WIDTH  to DRAM
- `dram_ready`, `dram_complete`, `valid`  in  1  from DRAM
- `rdata`  in  BURST_ACCESS_WIDTH  from DRAM

## Operation
- States: IDLE, ISSUE, BURST, RECOVER.
- IDLE: if any `req_valid`, the grant goes to the first set bit searching upward from `rr_ptr` with wrap-around. The arbiter latches index, `req_we`, and `req_addr`, pulses `req_accept[idx]`, and moves to ISSUE. It also sets `rr_ptr` to (idx+1) mod NUM_REQ.
- ISSUE: when `dram_ready`=1, assert `read_en` (we=0) or `write_en` (we=1) and go to BURST. Clear the watchdog counter.
- BURST: hold enable and `addr` constant.
  - Write: `wdata` = `req_wdata[idx]` combinationally, and `req_wbeat[idx]` = `valid`.
  - Read: `req_rdata` = `rdata` and `req_rvalid[idx]` = `valid`; registered 1 cycle, so both appear the cycle after DRAM `valid`.
  - On `dram_complete`=1: drop enable, pulse `req_done[idx]` on the next cycle, and go to RECOVER.
  - If the watchdog reaches `MAX_WAIT`-1 without complete: drop enable, pulse `req_err[idx]`, and go to RECOVER.
- RECOVER: count `RECOVERY_CYCLES`, then go to IDLE. Requests arriving meanwhile wait, and no accept is issued.
- Counters are unsigned and saturate; never wrap.
- `addr`/`wdata` = 0 when no grant is held.

## Timing
- Reset (`rst_n`=0 at a clock edge) gives state IDLE, `rr_ptr`=0, and all outputs 0. This includes `read_en`, `write_en`, `addr`, `wdata`, `req_*`.
- Reset mid-burst: enables drop the following cycle. No `req_done`/`req_err` pulse is issued for the killed burst.
- Request-to-accept latency: 1 cycle in IDLE (registered accept).
- Accept-to-enable: 1 cycle minimum; longer while `dram_ready`=0.
- `req_valid` dropped after accept does not cancel the burst.
- `dram_complete` and watchdog expiry in the same cycle: complete wins, so `req_done`, not `req_err`.
- Back-to-back requests from the same requester are served round-robin. A requester whose request stays asserted is re-granted only after the others.
- Minimum gap between enable deassert and the next enable: `RECOVERY_CYCLES`+2 cycles.

## Test plan
- Single read, req 0, addr 5 -> `req_accept`=0001, `read_en` high until `dram_complete`, BURST_LEN `req_rvalid[0]` pulses with data matching the DRAM row, then `req_done`=0001 once.
- Single write, req 2, addr 3, beats 0xA0..0xA7 -> each beat consumed on `req_wbeat[2]`, `write_en` held through complete, `req_done`=0100; a read of addr 3 returns the same beats.
- All four requesting continuously from reset -> grant order 0,1,2,3,0.
- Enable low for ≥`RECOVERY_CYCLES` between bursts; never both enables high.
- Stub DRAM never asserting `dram_complete`, MAX_WAIT=16 -> enable drops 16 cycles after issue, `req_err` pulses for the granted requester, arbiter returns to IDLE.
- `rst_n` low mid-write burst -> next cycle enables=0, all outputs 0, no done/err; a fresh request then grants requester 0 first.
